// File: rtl/ascon_pack.sv
// ascon_pack: shared ASCON state type, FSM encoding and column count
package ascon_pack;
    localparam int NB_COLS = 64;
    typedef logic [0:4][63:0] type_state;
    typedef enum logic [1:0] {IDLE, RUN, DONE} type_fsm;
endpackage

// File: rtl/inv_substitution_table.sv
// inv_substitution_table: combinational inverse ASCON 5-bit S-box
module inv_substitution_table (
    input  logic [4:0] din,
    output logic [4:0] dout
);
    localparam logic [4:0] inv_tab [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };
    assign dout = inv_tab[din];
endmodule

// File: rtl/inv_substitution_layer.sv
// inv_substitution_layer: iterative inverse ASCON substitution layer,
// COLS_PER_CYCLE columns per clock under a start/done handshake
module inv_substitution_layer
    import ascon_pack::*;
#(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      start_i,
    input  type_state state_i,
    output logic      ready_o,
    output logic      busy_o,
    output logic      done_o,
    output type_state state_o
);
    localparam int C = COLS_PER_CYCLE;
    localparam int N = NB_COLS / C;
    if (!(C == 1 || C == 2 || C == 4 || C == 8 || C == 16 || C == 32 || C == 64)) begin : g_bad
        $error("COLS_PER_CYCLE must be a power of two from 1 to 64");
    end
    type_fsm        fsm;
    logic [5:0]     cnt;
    logic [5:0]     base;
    logic           last;
    type_state      st;
    type_state      nxt;
    logic [5*C-1:0] col_in;
    logic [5*C-1:0] col_out;
    assign base    = 6'(cnt * C);
    assign last    = cnt == 6'(N - 1);
    assign state_o = st;
    // column j is {x0[j],...,x4[j]} with x0 as the MSB
    for (genvar c = 0; c < C; c++) begin : g_col
        logic [5:0] i;
        assign i = base + 6'(c);
        assign col_in[5*c +: 5] = {st[0][i], st[1][i], st[2][i], st[3][i], st[4][i]};
        inv_substitution_table u_tab (
            .din  (col_in[5*c +: 5]),
            .dout (col_out[5*c +: 5])
        );
    end
    always_comb begin
        nxt = st;
        for (int c = 0; c < C; c++)
            {nxt[0][base + 6'(c)], nxt[1][base + 6'(c)], nxt[2][base + 6'(c)],
             nxt[3][base + 6'(c)], nxt[4][base + 6'(c)]} = col_out[5*c +: 5];
    end
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm     <= IDLE;
            cnt     <= '0;
            st      <= '0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else if (fsm == RUN) begin
            st      <= nxt;
            cnt     <= last ? '0 : cnt + 6'd1;
            fsm     <= last ? DONE : RUN;
            ready_o <= last;
            busy_o  <= !last;
            done_o  <= last;
        end else if (start_i) begin
            st      <= state_i;
            cnt     <= '0;
            fsm     <= RUN;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
        end else begin
            fsm     <= IDLE;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end
    end
endmodule

// File: doc/inv_substitution_layer.md
# inv_substitution_layer

Iterative inverse ASCON substitution layer. It applies the inverse 5-bit S-box to all 64 columns of a 320-bit ASCON state, COLS_PER_CYCLE columns per clock, under a start/done handshake. It serves as the inverse-permutation datapath used by the permutation verification and round-trip checks. It sits beside the forward substitution layer and shares its state type.

## Interface
- COLS_PER_CYCLE, default 4: columns transformed per cycle. Legal values are 1, 2, 4, 8, 16, 32 or 64. Any other value is an elaboration error.
- clock_i  in  1  single clock, rising-edge.
- resetb_i  in  1  asynchronous active-low reset.
- start_i  in  1  request to load state_i and start a transform.
- state_i  in  type_state (5 x 64)  input state words x0..x4.
- ready_o  out  1  high when a start_i will be accepted.
- busy_o  out  1  high while columns are being transformed.
- done_o  out  1  one-cycle pulse; state_o holds the complete result.
- state_o  out  type_state (5 x 64)  working/result state.

## Operation
- Column j (0..63) is the 5-bit value {x0[j], x1[j], x2[j], x3[j], x4[j]}, with x0 as the MSB. Result bits are written back to the same positions.
- Inverse S-box, input→output, hex:
  - 00→14, 01→1a, 02→07, 03→0d, 04→00, 05→09, 06→0e, 07→12
  - 08→0a, 09→06, 0a→1d, 0b→01, 0c→19, 0d→15, 0e→13, 0f→1e
  - 10→18, 11→16, 12→0b, 13→11, 14→03, 15→05, 16→1c, 17→1f
  - 18→17, 19→1b, 1a→04, 1b→08, 1c→0f, 1d→0c, 1e→10, 1f→02
- FSM states are IDLE, RUN and DONE. N = 64 / COLS_PER_CYCLE. Column counter cnt is 6 bits wide.
- IDLE or DONE with start_i=1: load state_i into the register, set cnt=0, go to RUN.
- DONE with start_i=0: go to IDLE.
- RUN: each cycle, replace columns [cnt*C +: C] with their inverse and increment cnt.
  - On the chunk where cnt = N-1, go to DONE. cnt wraps to 0.
  - start_i is ignored in RUN. state_i is sampled only at load.
- ready_o is 1 in IDLE and DONE. busy_o is 1 in RUN. done_o is 1 in DONE only.
- state_o is the internal register at all times. It holds the result after DONE until the next load.
- Reset, at any time including mid-RUN: go to IDLE, cnt=0, state register=0, ready_o=1, busy_o=0, done_o=0. A partial transform is discarded.

## Timing
- Start accepted at rising edge k. Chunks are processed at edges k+1..k+N.
- The FSM enters DONE at edge k+N. done_o=1 and the full result is on state_o during the cycle after edge k+N.
- Latency from start edge to done_o is N cycles: 16 at the default, 64 for C=1, 1 for C=64.
- Back-to-back: start_i during DONE is accepted at that edge. Throughput is one transform per N+1 cycles.
- No combinational path from inputs to outputs. All outputs are registered or decoded from the FSM state.

## Structure
- Shared package ascon_pack provides:
  - the type_state typedef (array of 5 x logic[63:0]);
  - the state enum for IDLE/RUN/DONE;
  - the constant NB_COLS = 64.
- Sub-module inv_substitution_table: 5-bit in, 5-bit out, purely combinational, holds the table above. It is instantiated COLS_PER_CYCLE times via generate.
- A column mux/demux selects chunk cnt into and out of the state register.

## Test plan
- All-zero state_i, start, default C: done_o after 16 cycles; x0=x2=64'hFFFF_FFFF_FFFF_FFFF, x1=x3=x4=0.
- All-ones state_i: x3=64'hFFFF_FFFF_FFFF_FFFF, x0=x1=x2=x4=0; busy_o high exactly 16 cycles.
- Round trip with 100 random states:
  - apply the forward 5-bit S-box column-wise in the bench, then this block: result equals the original;
  - exhaustive check of the 32 inverse table entries through column 0.
- start_i held high during RUN: no restart, done_o after 16 cycles. The second start in DONE is accepted, with the next done_o 17 cycles after the first.
- resetb_i pulled low at cycle 5 of RUN: all outputs go to reset values immediately; no done_o follows.
- Elaborate with C=1 and C=64: latency 64 and 1 respectively. Same results as the all-zero and all-ones checks above.
